// File: rtl/vga_sync.sv
// VGA timing generator: pixel-tick divider, horizontal/vertical position
// counters, registered sync outputs and decoded blanking/frame markers.
module vga_sync #(
   parameter int CLK_DIV   = 2,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   // Pixel-tick divider; with a divide of one every clk is a pixel.
   generate
      if (CLK_DIV == 1) begin : g_nodiv
         assign p_tick = 1'b1;
      end else begin : g_div
         localparam int DIV_W = $clog2(CLK_DIV);
         localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
         logic [DIV_W-1:0] div;

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               div <= '0;
            else if (div == DIV_MAX)
               div <= '0;
            else
               div <= div + 1'b1;
         end

         assign p_tick = (div == DIV_MAX);
      end
   endgenerate

   logic [9:0] x_nxt, y_nxt;
   logic       hs_nxt, vs_nxt;

   always_comb begin
      x_nxt = pixel_x;
      y_nxt = pixel_y;
      if (p_tick) begin
         if (pixel_x == H_MAX) begin
            x_nxt = '0;
            y_nxt = (pixel_y == V_MAX) ? 10'd0 : pixel_y + 10'd1;
         end else begin
            x_nxt = pixel_x + 10'd1;
         end
      end
   end

   // Syncs decode the next count so the registered pulse lines up with the counters.
   always_comb begin
      hs_nxt = ~SYNC_POL;
      vs_nxt = ~SYNC_POL;
      if (x_nxt >= HS_START && x_nxt <= HS_END)
         hs_nxt = SYNC_POL;
      if (y_nxt >= VS_START && y_nxt <= VS_END)
         vs_nxt = SYNC_POL;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_x <= '0;
         pixel_y <= '0;
         hsync   <= ~SYNC_POL;
         vsync   <= ~SYNC_POL;
      end else begin
         pixel_x <= x_nxt;
         pixel_y <= y_nxt;
         hsync   <= hs_nxt;
         vsync   <= vs_nxt;
      end
   end

   assign video_on    = (pixel_x < H_VIS) && (pixel_y < V_VIS);
   assign frame_start = p_tick && (pixel_x == H_MAX) && (pixel_y == V_MAX);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: four builds checked every cycle against a clock-count
// model, plus literal pins on periods, pulse widths and reset behaviour.
module tb_vga_sync;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   bit run  = 1'b0;
   int n;   // clk edges since reset release

   always @(posedge clk or posedge reset) begin
      if (reset) n <= 0;
      else       n <= n + 1;
   end

   logic       d_hs, d_vs, d_von, d_pt, d_fs;  logic [9:0] d_x, d_y;
   logic       o_hs, o_vs, o_von, o_pt, o_fs;  logic [9:0] o_x, o_y;
   logic       s_hs, s_vs, s_von, s_pt, s_fs;  logic [9:0] s_x, s_y;
   logic       p_hs, p_vs, p_von, p_pt, p_fs;  logic [9:0] p_x, p_y;

   vga_sync u_def (.clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
      .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs));

   vga_sync #(.CLK_DIV(1)) u_d1 (.clk(clk), .reset(reset), .hsync(o_hs), .vsync(o_vs),
      .video_on(o_von), .p_tick(o_pt), .pixel_x(o_x), .pixel_y(o_y), .frame_start(o_fs));

   vga_sync #(.CLK_DIV(2), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_sm (.clk(clk), .reset(reset),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .p_tick(s_pt), .pixel_x(s_x),
      .pixel_y(s_y), .frame_start(s_fs));

   vga_sync #(.CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b1)) u_pol (.clk(clk),
      .reset(reset), .hsync(p_hs), .vsync(p_vs), .video_on(p_von), .p_tick(p_pt),
      .pixel_x(p_x), .pixel_y(p_y), .frame_start(p_fs));

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: position is simply the pixel index (edges / divide) folded by the totals.
   task automatic cmp_dut(input string nm, input int d, input int hd, input int hf,
                          input int hs, input int hb, input int vd, input int vf,
                          input int vs, input int vb, input bit pol,
                          input logic [9:0] ax, input logic [9:0] ay, input logic ahs,
                          input logic avs, input logic avon, input logic apt, input logic afs);
      int ht, vt, p, ex, ey, ept;
      ht  = hd + hf + hs + hb;
      vt  = vd + vf + vs + vb;
      p   = n / d;
      ex  = p % ht;
      ey  = (p / ht) % vt;
      ept = ((n % d) == d - 1) ? 1 : 0;
      chk({nm, ".x"}, int'(ax), ex);
      chk({nm, ".y"}, int'(ay), ey);
      chk({nm, ".hsync"}, int'(ahs), (ex >= hd + hf && ex < hd + hf + hs) ? int'(pol) : int'(!pol));
      chk({nm, ".vsync"}, int'(avs), (ey >= vd + vf && ey < vd + vf + vs) ? int'(pol) : int'(!pol));
      chk({nm, ".video_on"}, int'(avon), (ex < hd && ey < vd) ? 1 : 0);
      chk({nm, ".p_tick"}, int'(apt), ept);
      chk({nm, ".frame_start"}, int'(afs), (ept == 1 && ex == ht - 1 && ey == vt - 1) ? 1 : 0);
   endtask

   always @(negedge clk) begin
      if (run) begin
         cmp_dut("def", 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, d_x, d_y, d_hs, d_vs, d_von, d_pt, d_fs);
         cmp_dut("d1", 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, o_x, o_y, o_hs, o_vs, o_von, o_pt, o_fs);
         cmp_dut("sm", 2, 16, 2, 3, 3, 8, 2, 2, 2, 1'b0, s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs);
         cmp_dut("pol", 3, 16, 2, 3, 3, 8, 2, 2, 2, 1'b1, p_x, p_y, p_hs, p_vs, p_von, p_pt, p_fs);
      end
   end

   task automatic chk_reset_vals(input string nm, input logic [9:0] ax, input logic [9:0] ay,
                                 input logic ahs, input logic avs, input logic avon,
                                 input logic apt, input logic afs);
      chk({nm, ".rst_x"}, int'(ax), 0);
      chk({nm, ".rst_y"}, int'(ay), 0);
      chk({nm, ".rst_hsync"}, int'(ahs), 1);
      chk({nm, ".rst_vsync"}, int'(avs), 1);
      chk({nm, ".rst_video_on"}, int'(avon), 1);
      chk({nm, ".rst_p_tick"}, int'(apt), 0);
      chk({nm, ".rst_frame_start"}, int'(afs), 0);
   endtask

   int def_hs_low, def_y1_at, d1_hs_low, d1_pt_low, sm_vs_low, sm_fs_cnt, sm_fs_at;
   int pol_hs_high, pol_vs_high;

   initial begin
      def_hs_low = 0; def_y1_at = -1; d1_hs_low = 0; d1_pt_low = 0;
      sm_vs_low = 0; sm_fs_cnt = 0; sm_fs_at = -1; pol_hs_high = 0; pol_vs_high = 0;
      run = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("def", d_x, d_y, d_hs, d_vs, d_von, d_pt, d_fs);
      chk("pol.rst_hsync", int'(p_hs), 0);
      chk("pol.rst_vsync", int'(p_vs), 0);

      #2 reset = 1'b0;
      @(negedge clk);
      chk("def.first_tick", int'(d_pt), 1);
      chk("def.x_before_tick", int'(d_x), 0);
      @(negedge clk);
      chk("def.x_after_tick", int'(d_x), 1);
      chk("def.tick_low", int'(d_pt), 0);

      for (int i = 0; i < 1700; i++) begin
         @(negedge clk);
         if (n < 1600 && d_hs == 1'b0) def_hs_low++;
         if (def_y1_at < 0 && d_y == 10'd1) def_y1_at = n;
         if (n < 800 && o_hs == 1'b0) d1_hs_low++;
         if (o_pt == 1'b0) d1_pt_low++;
         if (n < 672 && s_vs == 1'b0) sm_vs_low++;
         if (n < 700 && s_fs == 1'b1) begin
            sm_fs_cnt++;
            sm_fs_at = n;
         end
         if (n == 672) begin
            chk("sm.wrap_x", int'(s_x), 0);
            chk("sm.wrap_y", int'(s_y), 0);
         end
         if (n < 72 && p_hs == 1'b1) pol_hs_high++;
         if (n < 1008 && p_vs == 1'b1) pol_vs_high++;
      end

      chk("def.hsync_low_clks", def_hs_low, 192);
      chk("def.line_period", def_y1_at, 1600);
      chk("d1.hsync_low_clks", d1_hs_low, 96);
      chk("d1.p_tick_low_clks", d1_pt_low, 0);
      chk("sm.vsync_low_clks", sm_vs_low, 96);
      chk("sm.frame_start_count", sm_fs_cnt, 1);
      chk("sm.frame_start_at", sm_fs_at, 671);
      chk("pol.hsync_high_clks", pol_hs_high, 9);
      chk("pol.vsync_high_clks", pol_vs_high, 144);

      // Asynchronous reset between edges, mid pixel period.
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk_reset_vals("def.async", d_x, d_y, d_hs, d_vs, d_von, d_pt, d_fs);
      chk_reset_vals("sm.async", s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("def.restart_tick", int'(d_pt), 1);
      @(negedge clk);
      chk("def.restart_x", int'(d_x), 1);
      repeat (100) @(negedge clk);

      run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
